spidergon_traffic_gen: RTL and testbench
========================================

Name: spidergon_traffic_gen

Overview:
Synthesizable per-node flit injector for the Spidergon NoC. It replaces the fixed reset-then-idle testbench stimulus with parametrised, rate-controlled packet traffic. The NoC top instantiates one per node, and its output drives that node's local injection port. It adds a post-reset hold window, destination patterns, per-packet virtual-channel rotation and sent-packet accounting.

Parameters:
NUM_OF_NODES, 8, ring size; power of two, >=4.
NODE_ID, 0, index of the attached node, 0..NUM_OF_NODES-1.
FLIT_DATA_WIDTH, 16, flit width; must be >= 2+DEST_W+VC_W+4.
NUM_OF_VIRTUAL_CHANNELS, 2, number of VCs rotated per packet.
MAX_PKT_LEN, 8, largest legal packet length in flits.
RESET_HOLD, 2, idle cycles after reset release before the first injection.
SEED, 16'hACE1, LFSR seed; a value of 0 is replaced by 16'hACE1.

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
enable  in  1  permit starting new packets
mode  in  2  destination pattern: 0 clockwise, 1 counter-clockwise, 2 across, 3 uniform random
rate  in  8  injection probability (rate+1)/256 per idle cycle
pkt_len  in  $clog2(MAX_PKT_LEN+1)  flits per packet; 0 is treated as 1; values above MAX_PKT_LEN clamp to MAX_PKT_LEN
flit_out  out  FLIT_DATA_WIDTH  flit data
flit_valid  out  1  flit_out is valid
flit_ready  in  1  node accepts the flit
vc_sel  out  $clog2(NUM_OF_VIRTUAL_CHANNELS)  VC for the current packet
busy  out  1  a packet is in flight
pkts_sent  out  16  tail flits accepted (count wraps)

Behaviour:
- Reset (reset=0, asynchronous) clears flit_out, flit_valid, vc_sel, busy and pkts_sent to 0. It loads the LFSR with SEED and enters WAIT_RESET.
- A reset assertion mid-packet aborts the packet immediately. No partial tail is emitted.
- Flit layout, MSB first: type[1:0] | dest[DEST_W-1:0] | vc[VC_W-1:0] | payload.
  - DEST_W = clog2(NUM_OF_NODES); VC_W = clog2(NUM_OF_VIRTUAL_CHANNELS).
  - type encodings: HEAD 2'b10, BODY 2'b00, TAIL 2'b01, HEAD_TAIL 2'b11.
- Payload content:
  - HEAD / HEAD_TAIL payload = packet sequence number (zero-extended or truncated to fit).
  - BODY / TAIL payload = flit index within the packet (1..len-1).
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle the FSM is in IDLE.
- FSM states:
  - WAIT_RESET: counts RESET_HOLD cycles after reset release, then moves to IDLE. With RESET_HOLD=0 it goes to IDLE on the first clock.
  - IDLE: if enable=1 and lfsr[7:0] <= rate, latch dest, vc and len, then go to SEND on the next cycle. busy=1 from that cycle.
  - SEND: drive flit_valid=1. A flit is accepted when flit_valid & flit_ready. On acceptance, advance the flit index; after the last flit go to IDLE, set busy=0 and increment pkts_sent.
- Handshake rules:
  - flit_out and vc_sel are held stable while flit_valid=1 and flit_ready=0.
  - flit_valid never drops without acceptance.
  - Back-to-back flits issue at 1 flit/cycle while flit_ready=1.
- Destination selection (all arithmetic mod NUM_OF_NODES):
  - mode 0: NODE_ID+1.
  - mode 1: NODE_ID-1 (so NODE_ID 0 wraps to N-1).
  - mode 2: NODE_ID+N/2.
  - mode 3: lfsr[15 -: DEST_W]; if this equals NODE_ID, use NODE_ID+1.
- vc_sel starts at 0 and rotates by +1 per packet start, wrapping at NUM_OF_VIRTUAL_CHANNELS-1 → 0.
- Dropping enable mid-packet has no effect on that packet; only new starts are gated.
- mode, rate and pkt_len are sampled only at packet start.
- Minimum gap between packets is 1 IDLE cycle.

Decomposition:
- Package noc_pkg holds:
  - flit type constants HEAD, BODY, TAIL, HEAD_TAIL;
  - FSM state enum;
  - width functions for DEST_W and VC_W;
  - the LFSR tap constant.
- One sub-module, noc_lfsr16: seed, advance enable and 16-bit state output; it is reusable by the future sink checker.

Test Plan:
- RESET_HOLD=2; release reset with enable=1, rate=255 → flit_valid stays 0 for 2 cycles after release; first HEAD appears no earlier than cycle 3.
- NODE_ID=0, mode=1, pkt_len=3, flit_ready=1 → flit types HEAD, BODY, TAIL on consecutive cycles with dest=7; pkts_sent=1 after the TAIL; vc_sel=0, then 1 on the next packet.
- mode=2, NODE_ID=5, pkt_len=1 → single HEAD_TAIL flit with dest=1; pkts_sent increments by 1 per flit.
- Hold flit_ready=0 for 4 cycles mid-packet → flit_out and flit_valid remain constant for those 4 cycles; the BODY index resumes without skipping.
- Deassert enable during the BODY of a 4-flit packet → the packet completes through TAIL; no further HEAD appears while enable=0.
- Assert reset during the 2nd flit → flit_valid=0 and busy=0 immediately (asynchronously); after release, the first packet carries vc=0 and sequence number 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the Spidergon traffic generator and future sink checker:
// flit type codes, injector FSM states, field-width helpers and LFSR constants.
package noc_pkg;

  localparam logic [1:0] HEAD      = 2'b10;
  localparam logic [1:0] BODY      = 2'b00;
  localparam logic [1:0] TAIL      = 2'b01;
  localparam logic [1:0] HEAD_TAIL = 2'b11;

  typedef enum logic [1:0] {
    WAIT_RESET = 2'd0,
    IDLE       = 2'd1,
    SEND       = 2'd2
  } state_t;

  // Taps 16,14,13,11 map to state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic int dest_w(input int num_nodes);
    return (num_nodes < 2) ? 1 : $clog2(num_nodes);
  endfunction

  // A single VC still needs a 1-bit field so the flit layout stays uniform.
  function automatic int vc_w(input int num_vcs);
    return (num_vcs < 2) ? 1 : $clog2(num_vcs);
  endfunction

endpackage

// File: rtl/noc_lfsr16.sv
// 16-bit Fibonacci LFSR with a hold control; a zero seed is replaced so the
// sequence can never lock up.
module noc_lfsr16
  import noc_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] state
);

  localparam logic [15:0] INIT = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
    end else if (advance) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/spidergon_traffic_gen.sv
// Per-node packet injector: rate-gated packet starts, destination patterns,
// per-packet VC rotation and a valid/ready flit stream with sent-packet count.
module spidergon_traffic_gen
  import noc_pkg::*;
#(
  parameter int          NUM_OF_NODES            = 8,
  parameter int          NODE_ID                 = 0,
  parameter int          FLIT_DATA_WIDTH         = 16,
  parameter int          NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter int          MAX_PKT_LEN             = 8,
  parameter int          RESET_HOLD              = 2,
  parameter logic [15:0] SEED                    = 16'hACE1,
  localparam int         DEST_W                  = dest_w(NUM_OF_NODES),
  localparam int         VC_W                    = vc_w(NUM_OF_VIRTUAL_CHANNELS),
  localparam int         LEN_W                   = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [7:0]                 rate,
  input  logic [LEN_W-1:0]           pkt_len,
  output logic [FLIT_DATA_WIDTH-1:0] flit_out,
  output logic                       flit_valid,
  input  logic                       flit_ready,
  output logic [VC_W-1:0]            vc_sel,
  output logic                       busy,
  output logic [15:0]                pkts_sent
);

  localparam int PAY_W  = FLIT_DATA_WIDTH - 2 - DEST_W - VC_W;
  localparam int HOLD_W = $clog2(RESET_HOLD + 2);

  localparam logic [DEST_W-1:0] NODE     = DEST_W'(NODE_ID);
  localparam logic [DEST_W-1:0] HALF     = DEST_W'(NUM_OF_NODES / 2);
  localparam logic [VC_W-1:0]   VC_LAST  = VC_W'(NUM_OF_VIRTUAL_CHANNELS - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_PKT_LEN);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [LEN_W-1:0]    idx;
  logic [LEN_W-1:0]    len_q;
  logic [DEST_W-1:0]   dest_q;
  logic [VC_W-1:0]     vc_next;
  logic [15:0]         seq;
  logic [15:0]         lfsr;

  logic                start;
  logic [LEN_W-1:0]    len_eff;
  logic [DEST_W-1:0]   dest_pick;
  logic [DEST_W-1:0]   dest_rnd;
  logic [LEN_W-1:0]    idx_nxt;
  logic                last;
  logic                tail_nxt;
  logic                lfsr_unused;

  function automatic logic [FLIT_DATA_WIDTH-1:0] make_flit(
    input logic [1:0]        ftype,
    input logic [DEST_W-1:0] dest,
    input logic [VC_W-1:0]   vc,
    input logic [PAY_W-1:0]  payload
  );
    return {ftype, dest, vc, payload};
  endfunction

  noc_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (state == IDLE),
    .state   (lfsr)
  );

  // Only the low byte (rate gate) and the top DEST_W bits (random dest) are consumed.
  assign lfsr_unused = ^lfsr;

  assign start    = (state == IDLE) && enable && (lfsr[7:0] <= rate);
  assign dest_rnd = lfsr[15 -: DEST_W];
  assign idx_nxt  = idx + LEN_ONE;
  assign last     = (idx_nxt == len_q);
  assign tail_nxt = (idx_nxt == (len_q - LEN_ONE));

  always_comb begin
    len_eff = pkt_len;
    if (pkt_len == '0) begin
      len_eff = LEN_ONE;
    end else if (pkt_len > LEN_MAX) begin
      len_eff = LEN_MAX;
    end
  end

  // Node indices are DEST_W wide, so plain truncating arithmetic is mod N.
  always_comb begin
    dest_pick = NODE + DEST_W'(1);
    case (mode)
      2'd0: dest_pick = NODE + DEST_W'(1);
      2'd1: dest_pick = NODE - DEST_W'(1);
      2'd2: dest_pick = NODE + HALF;
      2'd3: dest_pick = (dest_rnd == NODE) ? (NODE + DEST_W'(1)) : dest_rnd;
      default: dest_pick = NODE + DEST_W'(1);
    endcase
  end

  // Packet attributes captured at start; they only matter while in SEND.
  always_ff @(posedge clk) begin
    if (start) begin
      dest_q <= dest_pick;
      len_q  <= len_eff;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WAIT_RESET;
      hold_cnt   <= '0;
      idx        <= '0;
      vc_next    <= '0;
      seq        <= '0;
      flit_out   <= '0;
      flit_valid <= 1'b0;
      vc_sel     <= '0;
      busy       <= 1'b0;
      pkts_sent  <= '0;
    end else begin
      case (state)
        WAIT_RESET: begin
          if (hold_cnt >= HOLD_W'(RESET_HOLD)) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        IDLE: begin
          if (start) begin
            state      <= SEND;
            busy       <= 1'b1;
            flit_valid <= 1'b1;
            idx        <= '0;
            vc_sel     <= vc_next;
            vc_next    <= (vc_next == VC_LAST) ? '0 : vc_next + VC_W'(1);
            seq        <= seq + 16'd1;
            flit_out   <= make_flit((len_eff == LEN_ONE) ? HEAD_TAIL : HEAD,
                                    dest_pick, vc_next, PAY_W'(seq));
          end
        end

        // flit_valid is always high here, so flit_ready alone means acceptance.
        SEND: begin
          if (flit_ready) begin
            if (last) begin
              state      <= IDLE;
              flit_valid <= 1'b0;
              busy       <= 1'b0;
              pkts_sent  <= pkts_sent + 16'd1;
            end else begin
              idx      <= idx_nxt;
              flit_out <= make_flit(tail_nxt ? TAIL : BODY, dest_q, vc_sel,
                                    PAY_W'(idx_nxt));
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spidergon_traffic_gen.sv
// Directed bench for spidergon_traffic_gen: two instances (node 5 and node 0)
// share stimulus; rate=255 makes every packet start deterministic.
module tb_spidergon_traffic_gen;

  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_HT   = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [7:0]  rate;
  logic [3:0]  pkt_len;
  logic        flit_ready;
  logic [15:0] flit_out, flit_out0;
  logic        flit_valid, flit_valid0;
  logic        vc_sel, vc_sel0;
  logic        busy, busy0;
  logic [15:0] pkts_sent, pkts_sent0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spidergon_traffic_gen #(.NUM_OF_NODES(8), .NODE_ID(5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .rate(rate),
    .pkt_len(pkt_len), .flit_out(flit_out), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .vc_sel(vc_sel), .busy(busy), .pkts_sent(pkts_sent)
  );

  spidergon_traffic_gen #(.NUM_OF_NODES(8), .NODE_ID(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .rate(rate),
    .pkt_len(pkt_len), .flit_out(flit_out0), .flit_valid(flit_valid0),
    .flit_ready(flit_ready), .vc_sel(vc_sel0), .busy(busy0), .pkts_sent(pkts_sent0)
  );

  function automatic logic [15:0] mk(input logic [1:0] t, input logic [2:0] d,
                                     input logic v, input logic [9:0] p);
    return {t, d, v, p};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b1; mode = 2'd1; rate = 8'd255; pkt_len = 4'd3;
    flit_ready = 1'b1;
    tick();
    total++; if (flit_out !== 16'h0) begin bad++; $display("FAIL rst_flit got=%h want=0000", flit_out); end
    total++; if ({flit_valid, busy, vc_sel} !== 3'b000) begin bad++; $display("FAIL rst_ctrl got=%b want=000", {flit_valid, busy, vc_sel}); end
    total++; if (pkts_sent !== 16'd0) begin bad++; $display("FAIL rst_pkts got=%0d want=0", pkts_sent); end
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (flit_valid !== 1'b0) begin bad++; $display("FAIL hold_valid cyc=%0d got=%b want=0", i + 1, flit_valid); end
    end
  endtask

  task automatic test_ccw;
    tick();
    total++; if (flit_out !== mk(T_HEAD, 3'd4, 1'b0, 10'd0)) begin bad++; $display("FAIL ccw_head got=%h want=%h", flit_out, mk(T_HEAD, 3'd4, 1'b0, 10'd0)); end
    total++; if (flit_out0 !== mk(T_HEAD, 3'd7, 1'b0, 10'd0)) begin bad++; $display("FAIL ccw_head_n0 got=%h want=%h", flit_out0, mk(T_HEAD, 3'd7, 1'b0, 10'd0)); end
    total++; if ({flit_valid, busy} !== 2'b11) begin bad++; $display("FAIL ccw_busy got=%b want=11", {flit_valid, busy}); end
    tick();
    total++; if (flit_out0 !== mk(T_BODY, 3'd7, 1'b0, 10'd1)) begin bad++; $display("FAIL ccw_body got=%h want=%h", flit_out0, mk(T_BODY, 3'd7, 1'b0, 10'd1)); end
    tick();
    total++; if (flit_out0 !== mk(T_TAIL, 3'd7, 1'b0, 10'd2)) begin bad++; $display("FAIL ccw_tail got=%h want=%h", flit_out0, mk(T_TAIL, 3'd7, 1'b0, 10'd2)); end
    tick();
    total++; if ({flit_valid, busy} !== 2'b00) begin bad++; $display("FAIL ccw_idle got=%b want=00", {flit_valid, busy}); end
    total++; if (pkts_sent0 !== 16'd1) begin bad++; $display("FAIL ccw_pkts1 got=%0d want=1", pkts_sent0); end
    tick();
    total++; if (flit_out0 !== mk(T_HEAD, 3'd7, 1'b1, 10'd1)) begin bad++; $display("FAIL ccw_head2 got=%h want=%h", flit_out0, mk(T_HEAD, 3'd7, 1'b1, 10'd1)); end
    total++; if (vc_sel0 !== 1'b1) begin bad++; $display("FAIL ccw_vc2 got=%b want=1", vc_sel0); end
    tick();
    tick();
    enable = 1'b0;
    tick();
    total++; if (pkts_sent !== 16'd2) begin bad++; $display("FAIL ccw_pkts2 got=%0d want=2", pkts_sent); end
    tick();
    total++; if (flit_valid !== 1'b0) begin bad++; $display("FAIL ccw_park got=%b want=0", flit_valid); end
  endtask

  task automatic test_across;
    mode = 2'd2; pkt_len = 4'd1; enable = 1'b1;
    tick();
    total++; if (flit_out !== mk(T_HT, 3'd1, 1'b0, 10'd2)) begin bad++; $display("FAIL across_ht got=%h want=%h", flit_out, mk(T_HT, 3'd1, 1'b0, 10'd2)); end
    total++; if (flit_out0 !== mk(T_HT, 3'd4, 1'b0, 10'd2)) begin bad++; $display("FAIL across_ht_n0 got=%h want=%h", flit_out0, mk(T_HT, 3'd4, 1'b0, 10'd2)); end
    tick();
    total++; if ({flit_valid, pkts_sent} !== {1'b0, 16'd3}) begin bad++; $display("FAIL across_cnt3 got=%b/%0d want=0/3", flit_valid, pkts_sent); end
    tick();
    total++; if (flit_out !== mk(T_HT, 3'd1, 1'b1, 10'd3)) begin bad++; $display("FAIL across_ht2 got=%h want=%h", flit_out, mk(T_HT, 3'd1, 1'b1, 10'd3)); end
    enable = 1'b0;
    tick();
    total++; if (pkts_sent !== 16'd4) begin bad++; $display("FAIL across_cnt4 got=%0d want=4", pkts_sent); end
    tick();
  endtask

  task automatic test_stall;
    mode = 2'd0; pkt_len = 4'd4; enable = 1'b1;
    tick();
    total++; if (flit_out !== mk(T_HEAD, 3'd6, 1'b0, 10'd4)) begin bad++; $display("FAIL stall_head got=%h want=%h", flit_out, mk(T_HEAD, 3'd6, 1'b0, 10'd4)); end
    enable = 1'b0;
    tick();
    flit_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({flit_valid, flit_out} !== {1'b1, mk(T_BODY, 3'd6, 1'b0, 10'd1)}) begin bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h want=1/%h", i, flit_valid, flit_out, mk(T_BODY, 3'd6, 1'b0, 10'd1)); end
    end
    flit_ready = 1'b1;
    tick();
    total++; if (flit_out !== mk(T_BODY, 3'd6, 1'b0, 10'd2)) begin bad++; $display("FAIL stall_resume got=%h want=%h", flit_out, mk(T_BODY, 3'd6, 1'b0, 10'd2)); end
    tick();
    total++; if (flit_out !== mk(T_TAIL, 3'd6, 1'b0, 10'd3)) begin bad++; $display("FAIL stall_tail got=%h want=%h", flit_out, mk(T_TAIL, 3'd6, 1'b0, 10'd3)); end
    tick();
    total++; if ({flit_valid, pkts_sent} !== {1'b0, 16'd5}) begin bad++; $display("FAIL stall_cnt got=%b/%0d want=0/5", flit_valid, pkts_sent); end
  endtask

  task automatic test_enable_drop;
    enable = 1'b1;
    tick();
    total++; if (flit_out !== mk(T_HEAD, 3'd6, 1'b1, 10'd5)) begin bad++; $display("FAIL en_head got=%h want=%h", flit_out, mk(T_HEAD, 3'd6, 1'b1, 10'd5)); end
    tick();
    enable = 1'b0;
    tick();
    tick();
    total++; if (flit_out !== mk(T_TAIL, 3'd6, 1'b1, 10'd3)) begin bad++; $display("FAIL en_tail got=%h want=%h", flit_out, mk(T_TAIL, 3'd6, 1'b1, 10'd3)); end
    tick();
    total++; if (pkts_sent !== 16'd6) begin bad++; $display("FAIL en_cnt got=%0d want=6", pkts_sent); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({flit_valid, busy} !== 2'b00) begin bad++; $display("FAIL en_gated cyc=%0d got=%b want=00", i, {flit_valid, busy}); end
    end
  endtask

  task automatic test_len_clamp;
    pkt_len = 4'd0; enable = 1'b1;
    tick();
    total++; if (flit_out !== mk(T_HT, 3'd6, 1'b0, 10'd6)) begin bad++; $display("FAIL len0_ht got=%h want=%h", flit_out, mk(T_HT, 3'd6, 1'b0, 10'd6)); end
    enable = 1'b0;
    tick();
    total++; if ({flit_valid, pkts_sent} !== {1'b0, 16'd7}) begin bad++; $display("FAIL len0_cnt got=%b/%0d want=0/7", flit_valid, pkts_sent); end
    pkt_len = 4'd15; enable = 1'b1;
    tick();
    total++; if (flit_out !== mk(T_HEAD, 3'd6, 1'b1, 10'd7)) begin bad++; $display("FAIL len15_head got=%h want=%h", flit_out, mk(T_HEAD, 3'd6, 1'b1, 10'd7)); end
    enable = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      total++; if (flit_out !== mk((i == 7) ? T_TAIL : T_BODY, 3'd6, 1'b1, 10'(i))) begin bad++; $display("FAIL len15_flit idx=%0d got=%h want=%h", i, flit_out, mk((i == 7) ? T_TAIL : T_BODY, 3'd6, 1'b1, 10'(i))); end
    end
    tick();
    total++; if ({flit_valid, pkts_sent} !== {1'b0, 16'd8}) begin bad++; $display("FAIL len15_cnt got=%b/%0d want=0/8", flit_valid, pkts_sent); end
  endtask

  task automatic test_random;
    mode = 2'd3; pkt_len = 4'd1; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (!(flit_valid === 1'b1 && flit_out[15:14] === T_HT && flit_out[13:11] !== 3'd5)) begin bad++; $display("FAIL rnd_dest pkt=%0d got=%b/%h want=valid HEAD_TAIL dest!=5", i, flit_valid, flit_out); end
      total++; if (!(flit_valid0 === 1'b1 && flit_out0[13:11] !== 3'd0)) begin bad++; $display("FAIL rnd_dest_n0 pkt=%0d got=%b/%h want=valid dest!=0", i, flit_valid0, flit_out0); end
      if (i == 3) enable = 1'b0;
      tick();
    end
    total++; if ({flit_valid, pkts_sent} !== {1'b0, 16'd12}) begin bad++; $display("FAIL rnd_cnt got=%b/%0d want=0/12", flit_valid, pkts_sent); end
  endtask

  task automatic test_reset_mid;
    mode = 2'd0; pkt_len = 4'd3; enable = 1'b1;
    tick();
    total++; if (flit_out !== mk(T_HEAD, 3'd6, 1'b0, 10'd12)) begin bad++; $display("FAIL rmid_head got=%h want=%h", flit_out, mk(T_HEAD, 3'd6, 1'b0, 10'd12)); end
    tick();
    total++; if (flit_out !== mk(T_BODY, 3'd6, 1'b0, 10'd1)) begin bad++; $display("FAIL rmid_body got=%h want=%h", flit_out, mk(T_BODY, 3'd6, 1'b0, 10'd1)); end
    #2 reset = 1'b0;
    #1;
    total++; if ({flit_valid, busy, vc_sel} !== 3'b000) begin bad++; $display("FAIL rmid_async got=%b want=000", {flit_valid, busy, vc_sel}); end
    total++; if ({flit_out, pkts_sent} !== 32'h0) begin bad++; $display("FAIL rmid_clear got=%h/%0d want=0/0", flit_out, pkts_sent); end
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (flit_valid !== 1'b0) begin bad++; $display("FAIL rmid_hold cyc=%0d got=%b want=0", i + 1, flit_valid); end
    end
    tick();
    total++; if ({flit_valid, flit_out} !== {1'b1, mk(T_HEAD, 3'd6, 1'b0, 10'd0)}) begin bad++; $display("FAIL rmid_first got=%b/%h want=1/%h", flit_valid, flit_out, mk(T_HEAD, 3'd6, 1'b0, 10'd0)); end
  endtask

  initial begin
    test_reset();
    test_ccw();
    test_across();
    test_stall();
    test_enable_drop();
    test_len_clamp();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
